// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures the decoded control bundle and operand fields for EX, with hold, flush and bubble counting.
// Optional load-use hazard detection is built in when ID_EX_LOADUSE_DETECT_EN is defined.
module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [19:0]       id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [5:0]        id_funct,
  output logic              ex_valid,
  output logic [19:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_funct,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int MEM_READ_BIT = 18;

  logic loadBubble;
  logic cntSat;

`ifdef ID_EX_LOADUSE_DETECT_EN
  // A load in EX whose destination feeds the ID instruction cannot forward in time.
  assign load_use_stall = ex_valid & ex_ctrl[MEM_READ_BIT] & (ex_rt != 5'd0) & id_valid &
                          ((ex_rt == id_rs) | (ex_rt == id_rt));
`else
  assign load_use_stall = 1'b0;
`endif

  assign loadBubble = flush | load_use_stall;
  assign cntSat     = &bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_funct   <= '0;
      bubble_cnt <= '0;
    end else if (loadBubble) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_funct   <= '0;
      if (!cntSat) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (!hold) begin
      ex_valid   <= id_valid;
      // Invalid slots carry no control so a stray RegWrite/MemWrite can never commit.
      ex_ctrl    <= id_valid ? id_ctrl : 20'd0;
      ex_pc4     <= id_pc4;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_shamt   <= id_shamt;
      ex_funct   <= id_funct;
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: directed vectors push hand-computed expectations, a monitor checks each edge.
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0, flush = 1'b0, idValid = 1'b0;
  logic [19:0] idCtrl = '0;
  logic [31:0] idPc4 = '0, idRsData = '0, idRtData = '0, idImm = '0;
  logic [4:0]  idRs = '0, idRt = '0, idRd = '0, idShamt = '0;
  logic [5:0]  idFunct = '0;

  logic        exValid, stall;
  logic [19:0] exCtrl;
  logic [31:0] exPc4, exRsData, exRtData, exImm;
  logic [4:0]  exRs, exRt, exRd, exShamt;
  logic [5:0]  exFunct;
  logic [15:0] bubbleCnt;

  logic        sValid, sStall;
  logic [19:0] sCtrl;
  logic [31:0] sPc4, sRsData, sRtData, sImm;
  logic [4:0]  sRs, sRt, sRd, sShamt;
  logic [5:0]  sFunct;
  logic [1:0]  satCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [19:0] ctrl;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [4:0]  rt;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t scoreQ[$];

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(idValid), .id_ctrl(idCtrl),
    .id_pc4(idPc4), .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm(idImm),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .id_shamt(idShamt), .id_funct(idFunct),
    .ex_valid(exValid), .ex_ctrl(exCtrl), .ex_pc4(exPc4), .ex_rs_data(exRsData),
    .ex_rt_data(exRtData), .ex_imm(exImm), .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd),
    .ex_shamt(exShamt), .ex_funct(exFunct), .load_use_stall(stall), .bubble_cnt(bubbleCnt)
  );

  id_ex_pipeline_reg #(.DATA_W(32), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(idValid), .id_ctrl(idCtrl),
    .id_pc4(idPc4), .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm(idImm),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .id_shamt(idShamt), .id_funct(idFunct),
    .ex_valid(sValid), .ex_ctrl(sCtrl), .ex_pc4(sPc4), .ex_rs_data(sRsData),
    .ex_rt_data(sRtData), .ex_imm(sImm), .ex_rs(sRs), .ex_rt(sRt), .ex_rd(sRd),
    .ex_shamt(sShamt), .ex_funct(sFunct), .load_use_stall(sStall), .bubble_cnt(satCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [19:0] c, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic [4:0] rt,
                              input logic [15:0] cnt, input logic [1:0] sat);
    exp_t e;
    e.valid = v; e.ctrl = c; e.rsd = rsd; e.rtd = rtd; e.rt = rt; e.cnt = cnt; e.sat = sat;
    return e;
  endfunction

  // Drive one cycle of stimulus at negedge; optionally check the stall output and queue the post-edge expectation.
  task automatic cyc(input logic h, input logic f, input logic v, input logic [19:0] c,
                     input logic [31:0] d, input logic [4:0] rs, input logic [4:0] rt,
                     input bit doStall, input logic expStall, input exp_t e);
    @(negedge clk);
    hold = h; flush = f; idValid = v; idCtrl = c;
    idRsData = d; idRtData = ~d; idImm = d ^ 32'h0000_FFFF; idPc4 = d + 32'd4;
    idRs = rs; idRt = rt; idRd = d[4:0]; idShamt = d[9:5]; idFunct = d[5:0];
    scoreQ.push_back(e);
    #1;
    if (doStall) chk("load_use_stall", {31'd0, stall}, {31'd0, expStall});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreQ.size() != 0) begin
        e = scoreQ.pop_front();
        chk("ex_valid", {31'd0, exValid}, {31'd0, e.valid});
        chk("ex_ctrl", {12'd0, exCtrl}, {12'd0, e.ctrl});
        chk("ex_rs_data", exRsData, e.rsd);
        chk("ex_rt_data", exRtData, e.rtd);
        chk("ex_rt", {27'd0, exRt}, {27'd0, e.rt});
        chk("bubble_cnt", {16'd0, bubbleCnt}, {16'd0, e.cnt});
        chk("sat_bubble_cnt", {30'd0, satCnt}, {30'd0, e.sat});
      end
    end
  end

  initial begin : driver
    bit en;
`ifdef ID_EX_LOADUSE_DETECT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    #3;
    chk("reset_ex_valid", {31'd0, exValid}, 32'd0);
    chk("reset_ex_ctrl", {12'd0, exCtrl}, 32'd0);
    chk("reset_bubble_cnt", {16'd0, bubbleCnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through and hold
    cyc(0, 0, 1, 20'hA5A5A, 32'h1234_5678, 5'd0, 5'd0, 0, 0, mk(1, 20'hA5A5A, 32'h1234_5678, 32'hEDCB_A987, 5'd0, 0, 0));
    cyc(0, 0, 1, 20'h12345, 32'hDEAD_BEEF, 5'd1, 5'd3, 0, 0, mk(1, 20'h12345, 32'hDEAD_BEEF, 32'h2152_4110, 5'd3, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 1, 20'hFFFFF, 32'h1111_1111, 5'd2, 5'd7, 0, 0, mk(1, 20'h12345, 32'hDEAD_BEEF, 32'h2152_4110, 5'd3, 0, 0));
    // Flush wins over hold
    cyc(1, 1, 1, 20'hFFFFF, 32'h1111_1111, 5'd2, 5'd7, 0, 0, mk(0, 20'h0, 32'h0, 32'h0, 5'd0, 1, 1));
    // Invalid slot: control cleared, data still passes, not counted
    cyc(0, 0, 0, 20'hFFFFF, 32'hCAFE_F00D, 5'd0, 5'd4, 0, 0, mk(0, 20'h0, 32'hCAFE_F00D, 32'h3501_0FF2, 5'd4, 1, 1));
    // Four more flushes: narrow counter saturates at 3
    cyc(0, 1, 1, 20'h00001, 32'h9, 5'd0, 5'd0, 0, 0, mk(0, 20'h0, 32'h0, 32'h0, 5'd0, 2, 2));
    cyc(0, 1, 1, 20'h00001, 32'h9, 5'd0, 5'd0, 0, 0, mk(0, 20'h0, 32'h0, 32'h0, 5'd0, 3, 3));
    cyc(0, 1, 1, 20'h00001, 32'h9, 5'd0, 5'd0, 0, 0, mk(0, 20'h0, 32'h0, 32'h0, 5'd0, 4, 3));
    cyc(0, 1, 1, 20'h00001, 32'h9, 5'd0, 5'd0, 0, 0, mk(0, 20'h0, 32'h0, 32'h0, 5'd0, 5, 3));
    cyc(0, 0, 1, 20'h00001, 32'h0000_0042, 5'd0, 5'd0, 0, 0, mk(1, 20'h00001, 32'h0000_0042, 32'hFFFF_FFBD, 5'd0, 5, 3));

    // Load-use: lw rt=5 then add rs=5
    cyc(0, 0, 1, 20'h40000, 32'h1000, 5'd1, 5'd5, 1, 0, mk(1, 20'h40000, 32'h1000, 32'hFFFF_EFFF, 5'd5, 5, 3));
    if (en)
      cyc(0, 0, 1, 20'h80000, 32'h2000, 5'd5, 5'd6, 1, 1, mk(0, 20'h0, 32'h0, 32'h0, 5'd0, 6, 3));
    else
      cyc(0, 0, 1, 20'h80000, 32'h2000, 5'd5, 5'd6, 1, 0, mk(1, 20'h80000, 32'h2000, 32'hFFFF_DFFF, 5'd6, 5, 3));
    cyc(0, 0, 1, 20'h80000, 32'h2000, 5'd5, 5'd6, 1, 0,
        mk(1, 20'h80000, 32'h2000, 32'hFFFF_DFFF, 5'd6, en ? 16'd6 : 16'd5, 3));
    // Load to r0 never stalls
    cyc(0, 0, 1, 20'h40000, 32'h3000, 5'd2, 5'd0, 1, 0,
        mk(1, 20'h40000, 32'h3000, 32'hFFFF_CFFF, 5'd0, en ? 16'd6 : 16'd5, 3));
    cyc(0, 0, 1, 20'h80000, 32'h4000, 5'd0, 5'd0, 1, 0,
        mk(1, 20'h80000, 32'h4000, 32'hFFFF_BFFF, 5'd0, en ? 16'd6 : 16'd5, 3));

    for (int i = 0; i < 5 && scoreQ.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", scoreQ.size(), 32'd0);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_ex_valid", {31'd0, exValid}, 32'd0);
    chk("async_ex_ctrl", {12'd0, exCtrl}, 32'd0);
    chk("async_ex_rs_data", exRsData, 32'd0);
    chk("async_bubble_cnt", {16'd0, bubbleCnt}, 32'd0);
    chk("async_sat_cnt", {30'd0, satCnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 20'h00ABC, 32'h55AA_55AA, 5'd3, 5'd9, 1, 0, mk(1, 20'h00ABC, 32'h55AA_55AA, 32'hAA55_AA55, 5'd9, 0, 0));

    for (int i = 0; i < 5 && scoreQ.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained_end", scoreQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
